// File: rtl/ixu_pkg.sv
// Shared types for the IXU issue path.
// Op encoding, register-file geometry and the per-lane field bundle.
package ixu_pkg;

  localparam int OP_W   = 5;
  localparam int REG_AW = 5;
  localparam int NREGS  = 32;

  typedef enum logic [OP_W-1:0] {
    ADD  = 5'h00,
    SUB  = 5'h01,
    XOR  = 5'h02,
    OR   = 5'h03,
    AND  = 5'h04,
    SLL  = 5'h05,
    SRL  = 5'h06,
    SRA  = 5'h07,
    SLT  = 5'h08,
    SLTU = 5'h09,
    INV  = 5'h0F
  } ixu_op_e;

  typedef struct packed {
    ixu_op_e             op;
    logic [REG_AW-1:0]   rd;
    logic [REG_AW-1:0]   rs1;
    logic [REG_AW-1:0]   rs2;
    logic                is_imm;
  } lane_t;

endpackage

// File: rtl/ixu_scoreboard.sv
// Per-register busy counters for x1..x31 (x0 never busy).
// Ports: clk/rst, set_en/set_rd per lane, rd_addr (3 per lane) -> busy.
module ixu_scoreboard
  import ixu_pkg::*;
#(
  parameter int LANES = 2,
  parameter int LAT   = 2,
  parameter int CNT_W = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [LANES-1:0]            set_en,
  input  logic [LANES*REG_AW-1:0]     set_rd,
  input  logic [3*LANES*REG_AW-1:0]   rd_addr,
  output logic [3*LANES-1:0]          busy
);

  // The accept cycle is the first of the LAT busy cycles, so the
  // register holds LAT-1 and a dependent issues exactly LAT later.
  localparam logic [CNT_W-1:0] SET_VAL = CNT_W'(LAT - 1);

  logic [CNT_W-1:0] cnt_q [NREGS];
  logic [CNT_W-1:0] cnt_d [NREGS];

  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - 1'b1 : '0;
      // a new set overrides a coincident expiry
      for (int i = 0; i < LANES; i++) begin
        if (set_en[i] && r != 0 &&
            set_rd[i*REG_AW +: REG_AW] == REG_AW'(r))
          cnt_d[r] = SET_VAL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++)
        cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++)
        cnt_q[r] <= cnt_d[r];
    end
  end

  always_comb begin
    for (int k = 0; k < 3*LANES; k++)
      busy[k] = (cnt_q[rd_addr[k*REG_AW +: REG_AW]] != '0);
  end

endmodule

// File: rtl/ixu_issue_sched.sv
// IXU issue scheduler: hazard check, atomic bundle issue, stall count.
// Ports: bnd_* request in, bnd_ready out, iss_* registered issue out.
module ixu_issue_sched
  import ixu_pkg::*;
#(
  parameter int LANES = 2,
  parameter int LAT   = 2,
  parameter int CNT_W = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    bnd_valid,
  output logic                    bnd_ready,
  input  logic [LANES-1:0]        bnd_lane_en,
  input  logic [LANES*OP_W-1:0]   bnd_op,
  input  logic [LANES-1:0]        bnd_is_imm,
  input  logic [LANES*REG_AW-1:0] bnd_rd,
  input  logic [LANES*REG_AW-1:0] bnd_rs1,
  input  logic [LANES*REG_AW-1:0] bnd_rs2,
  input  logic                    flush,
  output logic [LANES-1:0]        iss_valid,
  output logic [LANES*OP_W-1:0]   iss_op,
  output logic [LANES*REG_AW-1:0] iss_rd,
  output logic [LANES*REG_AW-1:0] iss_rs1,
  output logic [LANES*REG_AW-1:0] iss_rs2,
  output logic [LANES-1:0]        iss_is_imm,
  output logic                    bnd_err,
  output logic [15:0]             stall_cnt
);

  lane_t bnd_l [LANES];
  lane_t iss_l_q [LANES];
  lane_t iss_l_d [LANES];

  logic [LANES-1:0]          iss_valid_q, iss_valid_d;
  logic                      bnd_err_q, bnd_err_d;
  logic [15:0]               stall_cnt_q, stall_cnt_d;
  logic [LANES-1:0]          set_en;
  logic [3*LANES*REG_AW-1:0] rd_addr;
  logic [3*LANES-1:0]        busy;
  logic                      hazard, waw, accept, do_iss;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      bnd_l[i].op     = ixu_op_e'(bnd_op[i*OP_W +: OP_W]);
      bnd_l[i].rd     = bnd_rd[i*REG_AW +: REG_AW];
      bnd_l[i].rs1    = bnd_rs1[i*REG_AW +: REG_AW];
      bnd_l[i].rs2    = bnd_rs2[i*REG_AW +: REG_AW];
      bnd_l[i].is_imm = bnd_is_imm[i];
    end
  end

  // read slots per lane: rs1, rs2, rd
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      rd_addr[(3*i+0)*REG_AW +: REG_AW] = bnd_l[i].rs1;
      rd_addr[(3*i+1)*REG_AW +: REG_AW] = bnd_l[i].rs2;
      rd_addr[(3*i+2)*REG_AW +: REG_AW] = bnd_l[i].rd;
    end
  end

  always_comb begin
    hazard = 1'b0;
    waw    = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (bnd_lane_en[i] &&
          (busy[3*i] ||
           (busy[3*i+1] && !bnd_l[i].is_imm) ||
           busy[3*i+2]))
        hazard = 1'b1;
      for (int j = i + 1; j < LANES; j++) begin
        if (bnd_lane_en[i] && bnd_lane_en[j] &&
            bnd_l[i].rd != '0 && bnd_l[i].rd == bnd_l[j].rd)
          waw = 1'b1;
      end
    end
  end

  assign bnd_ready = !hazard;
  assign accept    = bnd_valid && bnd_ready && !rst;
  assign do_iss    = accept && !waw && !flush;

  always_comb begin
    for (int i = 0; i < LANES; i++)
      set_en[i] = do_iss && bnd_lane_en[i] && bnd_l[i].rd != '0;
  end

  ixu_scoreboard #(
    .LANES (LANES),
    .LAT   (LAT),
    .CNT_W (CNT_W)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (set_en),
    .set_rd  (bnd_rd),
    .rd_addr (rd_addr),
    .busy    (busy)
  );

  always_comb begin
    iss_valid_d = do_iss ? bnd_lane_en : '0;
    bnd_err_d   = accept && waw && !flush;
    stall_cnt_d = stall_cnt_q;
    if (bnd_valid && hazard && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
    for (int i = 0; i < LANES; i++)
      iss_l_d[i] = do_iss ? bnd_l[i] : iss_l_q[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iss_valid_q <= '0;
      bnd_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      for (int i = 0; i < LANES; i++)
        iss_l_q[i] <= '0;
    end else begin
      iss_valid_q <= iss_valid_d;
      bnd_err_q   <= bnd_err_d;
      stall_cnt_q <= stall_cnt_d;
      for (int i = 0; i < LANES; i++)
        iss_l_q[i] <= iss_l_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      iss_op[i*OP_W +: OP_W]       = iss_l_q[i].op;
      iss_rd[i*REG_AW +: REG_AW]   = iss_l_q[i].rd;
      iss_rs1[i*REG_AW +: REG_AW]  = iss_l_q[i].rs1;
      iss_rs2[i*REG_AW +: REG_AW]  = iss_l_q[i].rs2;
      iss_is_imm[i]                = iss_l_q[i].is_imm;
    end
  end

  assign iss_valid = iss_valid_q;
  assign bnd_err   = bnd_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_ixu_issue_sched.sv
// Bench for ixu_issue_sched: directed scenarios then random bundles,
// checked against a register-availability-time reference model.
module tb_ixu_issue_sched;
  import ixu_pkg::*;

  localparam int LANES = 2;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        bnd_valid;
  logic        bnd_ready;
  logic [1:0]  bnd_lane_en;
  logic [9:0]  bnd_op;
  logic [1:0]  bnd_is_imm;
  logic [9:0]  bnd_rd, bnd_rs1, bnd_rs2;
  logic        flush;
  logic [1:0]  iss_valid;
  logic [9:0]  iss_op, iss_rd, iss_rs1, iss_rs2;
  logic [1:0]  iss_is_imm;
  logic        bnd_err;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  ixu_issue_sched #(.LANES(LANES), .LAT(LAT), .CNT_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .bnd_valid   (bnd_valid),
    .bnd_ready   (bnd_ready),
    .bnd_lane_en (bnd_lane_en),
    .bnd_op      (bnd_op),
    .bnd_is_imm  (bnd_is_imm),
    .bnd_rd      (bnd_rd),
    .bnd_rs1     (bnd_rs1),
    .bnd_rs2     (bnd_rs2),
    .flush       (flush),
    .iss_valid   (iss_valid),
    .iss_op      (iss_op),
    .iss_rd      (iss_rd),
    .iss_rs1     (iss_rs1),
    .iss_rs2     (iss_rs2),
    .iss_is_imm  (iss_is_imm),
    .bnd_err     (bnd_err),
    .stall_cnt   (stall_cnt)
  );

  typedef struct {
    logic       en;
    logic [4:0] op, rd, rs1, rs2;
    logic       imm;
  } tl_t;

  tl_t  cur [2];
  logic cur_v, cur_f;
  // earliest cycle at which a register may be read/written again
  int   avail [32];
  int   cyc, exp_stall;
  int   errors, checks;
  bit   acc;

  function automatic tl_t mk(logic en, logic [4:0] op, logic [4:0] rd,
                             logic [4:0] rs1, logic [4:0] rs2, logic imm);
    tl_t t;
    t.en = en; t.op = op; t.rd = rd;
    t.rs1 = rs1; t.rs2 = rs2; t.imm = imm;
    return t;
  endfunction

  function automatic bit rbusy(logic [4:0] r);
    return (r != 0) && (cyc < avail[r]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(output bit accepted);
    bit haz, waw, iss, err;
    logic [1:0] ev;
    bnd_valid = cur_v;
    flush     = cur_f;
    for (int i = 0; i < 2; i++) begin
      bnd_lane_en[i]     = cur[i].en;
      bnd_op[i*5 +: 5]   = cur[i].op;
      bnd_rd[i*5 +: 5]   = cur[i].rd;
      bnd_rs1[i*5 +: 5]  = cur[i].rs1;
      bnd_rs2[i*5 +: 5]  = cur[i].rs2;
      bnd_is_imm[i]      = cur[i].imm;
    end
    #1;
    haz = 0;
    for (int i = 0; i < 2; i++)
      if (cur[i].en && (rbusy(cur[i].rs1) ||
          (!cur[i].imm && rbusy(cur[i].rs2)) || rbusy(cur[i].rd)))
        haz = 1;
    waw = cur[0].en && cur[1].en && cur[0].rd != 0 &&
          cur[0].rd == cur[1].rd;
    if (!rst) chk("ready", 32'(bnd_ready), 32'(!haz));
    accepted = cur_v && !haz && !rst;
    iss = accepted && !waw && !cur_f;
    err = accepted && waw && !cur_f;
    @(posedge clk);
    #1;
    if (rst) begin
      for (int r = 0; r < 32; r++) avail[r] = 0;
      exp_stall = 0;
    end else if (cur_v && haz && exp_stall < 65535) begin
      exp_stall++;
    end
    if (iss)
      for (int i = 0; i < 2; i++)
        if (cur[i].en && cur[i].rd != 0) avail[cur[i].rd] = cyc + LAT;
    cyc++;
    ev = iss ? {cur[1].en, cur[0].en} : 2'b00;
    chk("iss_valid", 32'(iss_valid), 32'(ev));
    chk("bnd_err", 32'(bnd_err), 32'(err));
    chk("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
    if (iss)
      for (int i = 0; i < 2; i++)
        if (cur[i].en) begin
          chk($sformatf("iss_op%0d", i), 32'(iss_op[i*5 +: 5]), 32'(cur[i].op));
          chk($sformatf("iss_rd%0d", i), 32'(iss_rd[i*5 +: 5]), 32'(cur[i].rd));
          chk($sformatf("iss_rs1_%0d", i), 32'(iss_rs1[i*5 +: 5]), 32'(cur[i].rs1));
          chk($sformatf("iss_rs2_%0d", i), 32'(iss_rs2[i*5 +: 5]), 32'(cur[i].rs2));
          chk($sformatf("iss_imm%0d", i), 32'(iss_is_imm[i]), 32'(cur[i].imm));
        end
  endtask

  task automatic idle(input int n);
    cur_v = 0; cur_f = 0;
    for (int k = 0; k < n; k++) cycle(acc);
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0; exp_stall = 0;
    for (int r = 0; r < 32; r++) avail[r] = 0;
    rst = 1; cur_f = 0; cur_v = 1;
    cur[0] = mk(1, 5'd0, 5'd10, 5'd11, 5'd12, 0);
    cur[1] = mk(0, 5'd0, 5'd0, 5'd0, 5'd0, 0);

    // reset with a valid bundle present, then it issues
    for (int k = 0; k < 3; k++) cycle(acc);
    chk("reset_no_accept", 32'(acc), 32'(0));
    rst = 0;
    cycle(acc);
    chk("first_accept", 32'(acc), 32'(1));
    idle(2);

    // back-to-back independent bundles
    cur_v = 1;
    cur[0] = mk(1, 5'd0, 5'd1, 5'd2, 5'd3, 0);
    cur[1] = mk(1, 5'd0, 5'd4, 5'd5, 5'd6, 0);
    cycle(acc);
    cur[0] = mk(1, 5'd0, 5'd7, 5'd8, 5'd9, 0);
    cur[1] = mk(1, 5'd1, 5'd13, 5'd14, 5'd15, 0);
    cycle(acc);
    idle(2);

    // RAW: one stall cycle, issue LAT after producer
    cur_v = 1;
    cur[0] = mk(1, 5'd2, 5'd5, 5'd11, 5'd12, 0);
    cur[1] = mk(0, 5'd0, 5'd0, 5'd0, 5'd0, 0);
    cycle(acc);
    cur[0] = mk(1, 5'd3, 5'd16, 5'd5, 5'd17, 0);
    cycle(acc);
    chk("raw_stalled", 32'(acc), 32'(0));
    cycle(acc);
    chk("raw_accept", 32'(acc), 32'(1));
    idle(1);
    chk("raw_stall_cnt", 32'(stall_cnt), 32'(1));
    idle(1);

    // x0 never busy; I-type ignores rs2
    cur_v = 1;
    cur[0] = mk(1, 5'd0, 5'd0, 5'd1, 5'd2, 0);
    cycle(acc);
    cur[0] = mk(1, 5'd0, 5'd18, 5'd0, 5'd0, 0);
    cycle(acc);
    chk("x0_no_stall", 32'(acc), 32'(1));
    cur[0] = mk(1, 5'd4, 5'd9, 5'd1, 5'd2, 0);
    cycle(acc);
    cur[0] = mk(1, 5'd4, 5'd19, 5'd1, 5'd9, 1);
    cycle(acc);
    chk("imm_no_stall", 32'(acc), 32'(1));
    idle(2);

    // intra-bundle WAW drop, then x3 is free
    cur_v = 1;
    cur[0] = mk(1, 5'd0, 5'd3, 5'd1, 5'd2, 0);
    cur[1] = mk(1, 5'd1, 5'd3, 5'd4, 5'd5, 0);
    cycle(acc);
    cur[0] = mk(1, 5'd0, 5'd20, 5'd3, 5'd3, 0);
    cur[1] = mk(0, 5'd0, 5'd0, 5'd0, 5'd0, 0);
    cycle(acc);
    chk("waw_x3_free", 32'(acc), 32'(1));
    idle(2);

    // flush on accept drops it; flush after accept keeps the counter
    cur_v = 1; cur_f = 1;
    cur[0] = mk(1, 5'd0, 5'd6, 5'd1, 5'd2, 0);
    cycle(acc);
    cur_f = 0;
    cur[0] = mk(1, 5'd0, 5'd21, 5'd6, 5'd6, 0);
    cycle(acc);
    chk("flush_no_set", 32'(acc), 32'(1));
    idle(2);
    cur_v = 1;
    cur[0] = mk(1, 5'd0, 5'd4, 5'd1, 5'd2, 0);
    cycle(acc);
    cur[0] = mk(1, 5'd0, 5'd22, 5'd4, 5'd1, 0);
    cur_f = 1;
    cycle(acc);
    chk("flush_x4_stall", 32'(acc), 32'(0));
    cur_f = 0;
    cycle(acc);
    chk("flush_x4_accept", 32'(acc), 32'(1));
    idle(2);

    // random bundles over a small register window
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++)
        cur[i] = mk(1'($urandom_range(0, 3) != 0),
                    5'($urandom_range(0, 15)),
                    5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)));
      if ($urandom_range(0, 5) == 0) begin
        idle(1);
      end else begin
        cur_v = 1;
        acc = 0;
        for (int k = 0; k < 16 && !acc; k++) begin
          cur_f = ($urandom_range(0, 7) == 0);
          cycle(acc);
        end
        chk("accept_timeout", 32'(acc), 32'(1));
      end
    end
    idle(3);

    // mid-run reset clears scoreboard and counters
    cur_v = 1; cur_f = 0;
    cur[0] = mk(1, 5'd0, 5'd8, 5'd1, 5'd2, 0);
    cur[1] = mk(0, 5'd0, 5'd0, 5'd0, 5'd0, 0);
    cycle(acc);
    rst = 1;
    cur[0] = mk(1, 5'd0, 5'd9, 5'd8, 5'd8, 0);
    cycle(acc);
    rst = 0;
    cycle(acc);
    chk("post_reset_accept", 32'(acc), 32'(1));
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
